// File: rtl/simple_adapter_pkg.sv
// Shared definitions for the simple_adapter / simple_unpacker width-conversion chain.
// The helpers are constant functions so every parameterised width is derived
// from the same rules on both sides of the chain.
package simple_adapter_pkg;

    // Output stage states: waiting for a word, or emitting its lanes.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } unpack_state_t;

    // Ceiling log2 for elaboration-time sizing (returns 0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Number of narrow lanes carried by one wide word.
    function automatic int calc_ratio(input int width_wide, input int width_narrow);
        return width_wide / width_narrow;
    endfunction

    // Width of a lane count that must be able to hold the value RATIO itself.
    function automatic int lane_width(input int ratio);
        return clog2(ratio) + 1;
    endfunction

endpackage

// File: rtl/simple_fifo.sv
// Small synchronous FIFO with show-ahead read data: rdata always presents the
// head entry, so the consumer can pop and use the word in the same cycle.
module simple_fifo
    import simple_adapter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    assign full  = (r_count == (AW + 1)'(DEPTH));
    assign empty = (r_count == '0);
    assign rdata = r_mem[r_rd_ptr];

    // Storage array: written on accepted pushes, never reset (contents are
    // only meaningful between the pointers).
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keeps count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/simple_unpacker.sv
// Wide-to-narrow serializer: buffers WIDTH_DIN words and emits them as
// WIDTH_DOUT beats, lane 0 (LSBs) first, honouring a per-packet lane count
// on the final word. A word arriving while the buffer is empty and the output
// stage wants data bypasses the FIFO so its first lane appears next cycle.
module simple_unpacker
    import simple_adapter_pkg::*;
#(
    parameter int WIDTH_DIN  = 128,
    parameter int WIDTH_DOUT = 16,
    parameter int DEPTH      = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  din_vld,
    output logic                                  din_rdy,
    input  logic                                  din_last,
    input  logic [clog2(WIDTH_DIN/WIDTH_DOUT):0]  din_lanes,
    input  logic [WIDTH_DIN-1:0]                  din,
    output logic                                  dout_vld,
    input  logic                                  dout_rdy,
    output logic                                  dout_last,
    output logic [WIDTH_DOUT-1:0]                 dout
);

    localparam int RATIO = calc_ratio(WIDTH_DIN, WIDTH_DOUT);
    localparam int LW    = lane_width(RATIO);
    localparam int PW    = WIDTH_DIN + 1 + LW;
    localparam logic [LW-1:0] LANES_FULL = LW'(RATIO);

    // Input side
    logic [LW-1:0]        w_in_lanes;
    logic [PW-1:0]        w_in_payload;
    logic                 w_push;

    // FIFO interface
    logic                 w_fifo_push;
    logic                 w_fifo_pop;
    logic [PW-1:0]        w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    // Word selected for loading into the output stage
    logic [PW-1:0]        w_head;
    logic [WIDTH_DIN-1:0] w_head_word;
    logic                 w_head_last;
    logic [LW-1:0]        w_head_lanes;

    // Output stage control
    logic                 w_last_lane;
    logic                 w_word_done;
    logic                 w_want;
    logic                 w_load;
    logic                 w_bypass;

    // Output stage registers
    unpack_state_t        r_state;
    logic [WIDTH_DIN-1:0] r_shift;
    logic [LW-1:0]        r_cnt;
    logic [LW-1:0]        r_lanes;
    logic                 r_last;

    // Lane count of an incoming word: full unless it is a last word with a
    // count in 1..RATIO; out-of-range counts fall back to a full word.
    always_comb begin
        w_in_lanes = LANES_FULL;
        if (din_last && (din_lanes != '0) && (din_lanes <= LANES_FULL)) begin
            w_in_lanes = din_lanes;
        end
    end

    assign w_in_payload = {din, din_last, w_in_lanes};

    // Ready only reflects buffer occupancy, never the downstream handshake.
    assign din_rdy = ~rst & ~w_fifo_full;
    assign w_push  = din_vld & din_rdy;

    assign w_last_lane = (r_cnt == (r_lanes - 1'b1));
    assign w_word_done = (r_state == ST_SHIFT) & dout_rdy & w_last_lane;
    assign w_want      = (r_state == ST_IDLE) | w_word_done;

    // A load can be fed from the FIFO head or, when the FIFO is empty, from
    // the word being pushed this very cycle.
    assign w_load      = w_want & (~w_fifo_empty | w_push);
    assign w_bypass    = w_load & w_fifo_empty;
    assign w_fifo_push = w_push & ~w_bypass;
    assign w_fifo_pop  = w_load & ~w_fifo_empty;

    assign w_head       = w_fifo_empty ? w_in_payload : w_fifo_rdata;
    assign w_head_word  = w_head[PW-1 -: WIDTH_DIN];
    assign w_head_last  = w_head[LW];
    assign w_head_lanes = w_head[LW-1:0];

    simple_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .wdata (w_in_payload),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // IDLE/SHIFT state machine: loads words, shifts out one lane per accepted
    // beat and chains straight into the next word without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_lanes <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_shift <= w_head_word;
                        r_cnt   <= '0;
                        r_lanes <= w_head_lanes;
                        r_last  <= w_head_last;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (dout_rdy) begin
                        if (!w_last_lane) begin
                            r_shift <= r_shift >> WIDTH_DOUT;
                            r_cnt   <= r_cnt + 1'b1;
                        end else if (w_load) begin
                            r_shift <= w_head_word;
                            r_cnt   <= '0;
                            r_lanes <= w_head_lanes;
                            r_last  <= w_head_last;
                        end else begin
                            // Clear the datapath so an idle output reads as zero.
                            r_shift <= '0;
                            r_cnt   <= '0;
                            r_last  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout      = r_shift[WIDTH_DOUT-1:0];
    assign dout_vld  = (r_state == ST_SHIFT);
    assign dout_last = dout_vld & r_last & w_last_lane;

endmodule

// File: doc/simple_unpacker.md
# simple_unpacker

Wide-to-narrow serializer that sits directly downstream of the `simple_adapter` width-doubling chain. It accepts `WIDTH_DIN` words with valid/last framing and emits them as `WIDTH_DIN/WIDTH_DOUT` narrow beats, least-significant lane first. This restores the original stream width for the consumer. A small input buffer and ready/valid handshakes on both sides let it absorb the adapter's bursty output and respect consumer backpressure.

## Interface
Parameters:
- `WIDTH_DIN`, default 128: input word width.
- `WIDTH_DOUT`, default 16: output beat width. `RATIO = WIDTH_DIN/WIDTH_DOUT` must be a power of 2, ≥2.
- `DEPTH`, default 2: input word buffer entries, power of 2, ≥2.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `din_vld`  in  1: input word valid.
- `din_rdy`  out  1: buffer can accept a word.
- `din_last`  in  1: word ends a packet.
- `din_lanes`  in  clog2(RATIO)+1: valid lanes in a `din_last` word, 1..RATIO. Ignored when `din_last`=0.
- `din`  in  WIDTH_DIN: input word.
- `dout_vld`  out  1: output beat valid.
- `dout_rdy`  in  1: consumer accepts the beat.
- `dout_last`  out  1: final beat of packet.
- `dout`  out  WIDTH_DOUT: output beat.

## Operation
- Push on `din_vld & din_rdy`: store `{din, din_last, lanes}` in the FIFO.
  - `lanes = din_last ? din_lanes : RATIO`.
  - `din_lanes` of 0 or >RATIO is treated as RATIO.
- Lane k is `din[k*WIDTH_DOUT +: WIDTH_DOUT]`. Lane 0 goes out first, matching the adapter, which packs the first narrow input into the LSBs.
- Output stage registers: word shift register, lane counter `cnt`, `lanes_q`, `last_q`. State machine has two states:
  - IDLE: `dout_vld`=0. When the FIFO is non-empty, pop, load the word, set `cnt`=0, go to SHIFT.
  - SHIFT: `dout` = current lane 0 of the shift register, `dout_vld`=1.
    - On `dout_rdy`: if `cnt == lanes_q-1`, the word is done. Otherwise shift right by `WIDTH_DOUT` and increment `cnt`.
    - On word done: if the FIFO is non-empty, pop and load the next word in the same cycle (no bubble) and stay in SHIFT. If empty, go to IDLE.
- `dout_last` = `last_q & (cnt == lanes_q-1)`. A non-last word yields exactly RATIO beats, all with `dout_last`=0.
- Lanes beyond `lanes_q` in a last word are never emitted.
- While `dout_vld & !dout_rdy`, `dout`, `dout_last` and `dout_vld` hold stable.
- `din_rdy` = FIFO not full. Its value comes from registered occupancy and does not depend combinationally on `dout_rdy`.

## Timing
- Reset values: `dout_vld`=0, `dout_last`=0, `dout`=0, `din_rdy`=0 while `rst` is high. `din_rdy`=1 from the first cycle after release. FIFO is empty, state is IDLE.
- Latency: a word pushed in cycle N with an empty FIFO and IDLE state gives `dout_vld`=1 with lane 0 in cycle N+1.
- Throughput: one beat per cycle while `dout_rdy`=1, including across word boundaries.
- Full FIFO: `din_rdy`=0. A pop in cycle N raises `din_rdy` in N+1.
- Simultaneous push and pop on a non-full FIFO: both happen and occupancy is unchanged.
- Empty FIFO at word end: exactly one IDLE cycle with `dout_vld`=0 only if no word arrives. A word pushed in the same cycle loads on the next edge.
- `rst` mid-packet: all buffered and in-flight data is discarded immediately. No partial packet or `dout_last` is emitted after release.

## Structure
- Shared package `simple_adapter_pkg`: a `clog2` helper, the `RATIO` computation, and the lane-count width constant. These are shared with `simple_adapter`.
- Sub-module `simple_fifo`: synchronous FIFO (`WIDTH`, `DEPTH`), asynchronous active-high reset, with `full`/`empty`/`push`/`pop`. Payload is `WIDTH_DIN + 1 + clog2(RATIO)+1` bits.
- The top level holds the shift register, lane counter and IDLE/SHIFT state.

## Test plan
- Reset and single word: push `din`=128'h0007_0006_..._0000 with `din_last`=0 and `dout_rdy`=1. Expect beats 0x0000..0x0007 on 8 consecutive cycles starting N+1, all with `dout_last`=0.
- Packet tail: 3 words, the last with `din_lanes`=3. Expect 8+8+3=19 beats with no gaps. Only beat 19 has `dout_last`=1, and its value is lane 2 of word 3.
- Backpressure: with `dout_rdy` random at 30% high, send 32 words. Expect `dout` stable whenever stalled, `din_rdy`=0 after 2 words are buffered plus 1 shifting, and an output sequence identical to the no-stall reference.
- End-to-end: chain `simple_adapter` ×3 (16→128) into `simple_unpacker` (128→16), driven by random 20%-valid 16-bit data with `din_last` at length 32. Output must equal the input sequence, with `dout_last` on beat 32.
- Reset mid-packet: assert `rst` after 5 beats of an 8-lane word. `dout_vld`=0 immediately and `din_rdy`=0. After release, a new word produces exactly 8 fresh beats.
- `din_lanes`=0 with `din_last`=1: expect 8 beats, `dout_last` on the 8th.
